// File: rtl/pipe_word_unpack.sv
// pipe_word_unpack: splits each wide word taken on the prev valid/ready interface into
// RATIO = IN_WIDTH/OUT_WIDTH narrow chunks presented on the next valid/ready interface.
// A single holding register is reloaded in the same cycle its last chunk leaves, so
// back-to-back words stream with no idle cycle.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-low reset
//   clear       synchronous flush, drops any held word
//   prev_data   incoming word          prev_valid / prev_ready  incoming handshake
//   next_data   current chunk          next_valid / next_ready  outgoing handshake
//   next_last   current chunk is the final chunk of its word
//   busy        a word is held
module pipe_word_unpack #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 2,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  prev_data,
  input  logic                 prev_valid,
  output logic                 prev_ready,
  output logic [OUT_WIDTH-1:0] next_data,
  output logic                 next_valid,
  input  logic                 next_ready,
  output logic                 next_last,
  output logic                 busy
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(RATIO - 1);

  if ((OUT_WIDTH > IN_WIDTH) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_params
    $error("pipe_word_unpack: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                full_q, full_d;

  logic                emit, last_emit, accept;
  logic [IDX_W-1:0]    sel;
  logic [RATIO-1:0][OUT_WIDTH-1:0] chunks;

  assign emit      = full_q & next_ready;
  assign last_emit = emit & (idx_q == LastIdx);
  // rst gates prev_ready so nothing looks acceptable while the block is held in reset.
  // next_ready -> prev_ready is intentional: the next word loads as the last chunk leaves.
  assign prev_ready = rst & ~clear & (~full_q | last_emit);
  assign accept     = prev_valid & prev_ready;

  assign chunks     = word_q;
  assign sel        = LSB_FIRST ? idx_q : (LastIdx - idx_q);
  assign next_data  = chunks[sel];
  assign next_valid = full_q;
  assign next_last  = full_q & (idx_q == LastIdx);
  assign busy       = full_q;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (clear) begin
      full_d = 1'b0;
      idx_d  = '0;
    end else if (accept) begin
      word_d = prev_data;
      idx_d  = '0;
      full_d = 1'b1;
    end else if (last_emit) begin
      full_d = 1'b0;
      idx_d  = '0;
    end else if (emit) begin
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule
